// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and registered valid/ready fetch stage with redirect, drain and halt
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        imem_exit,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc;
  logic end_hit, take, hs, redir;
  assign imem_addr = {2'b00, pc[31:2]};
  assign end_hit = imem_exit | (imem_addr >= MEM_DEPTH);
  assign hs = if_valid & if_ready;
  assign redir = redirect_valid & (state == FETCH || state == DRAIN);
  assign take = (state == FETCH) & ~end_hit & (~if_valid | if_ready);
  assign halted = state == HALT;
  always_comb begin
    state_n = redir ? FETCH :
              state == IDLE  ? (start ? FETCH : IDLE) :
              state == FETCH ? (end_hit ? ((if_valid & ~if_ready) ? DRAIN : HALT) : FETCH) :
              state == DRAIN ? (hs ? HALT : DRAIN) : HALT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= {RESET_PC[31:2], 2'b00};
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      if (hs && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
      if (redir) begin
        pc       <= {redirect_pc[31:2], 2'b00};
        if_valid <= 1'b0;
      end else if (take) begin
        if_instr <= imem_data;
        if_pc    <= pc;
        pc       <= pc + 32'd4;
        if_valid <= 1'b1;
      end else if (hs) begin
        if_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench; expected (pc,instr) pairs are queued per scenario and popped on each handshake
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_exit;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        halted;
  logic [31:0] fetch_count;
  logic [31:0] mem [64];
  logic        ex [64];
  logic [63:0] q [$];
  logic [63:0] e;
  int total = 0;
  int bad = 0;
  int n;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_exit(imem_exit), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign imem_data = (imem_addr < 64) ? mem[imem_addr[5:0]] : 32'h0;
  assign imem_exit = (imem_addr < 64) ? ex[imem_addr[5:0]] : 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (!reset && if_valid && if_ready) begin
      if (q.size() == 0) check("sb_extra", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        check("sb_pair", {if_pc, if_instr}, e);
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int words, input int exit_at);
    for (int i = 0; i < 64; i++) begin
      mem[i] = (i < words) ? 32'hA000 + 32'(i) * 32'h11 : 32'h0;
      ex[i]  = (i == exit_at);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0;
    step();
    reset = 1'b0;
    q.delete();
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_halt(input int bound, output int cnt);
    cnt = 0;
    while (!halted && cnt < bound) begin
      step();
      cnt++;
    end
    check("halt_reached", {63'd0, halted}, 64'd1);
  endtask

  initial begin
    load(4, 4);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    do_reset();
    check("rst_valid", {63'd0, if_valid}, 64'd0);
    check("rst_addr", {32'd0, imem_addr}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_count", {32'd0, fetch_count}, 64'd0);
    check("rst_instr_pc", {if_pc, if_instr}, 64'd0);
    q.push_back({32'd0, 32'h11}); q.push_back({32'd4, 32'h22});
    q.push_back({32'd8, 32'h33}); q.push_back({32'd12, 32'h44});
    if_ready = 1'b1;
    go();
    wait_halt(20, n);
    check("b2b_cycles", 64'(n), 64'd5);
    check("b2b_count", {32'd0, fetch_count}, 64'd4);
    check("b2b_addr", {32'd0, imem_addr}, 64'd4);
    check("b2b_valid", {63'd0, if_valid}, 64'd0);
    check("b2b_sb_empty", 64'(q.size()), 64'd0);

    do_reset();
    q.push_back({32'd0, 32'h11}); q.push_back({32'd4, 32'h22});
    q.push_back({32'd8, 32'h33}); q.push_back({32'd12, 32'h44});
    go();
    step();
    for (int i = 0; i < 4; i++) begin
      check("stall_pair", {if_pc, if_instr}, {32'd0, 32'h11});
      check("stall_addr", {32'd0, imem_addr}, 64'd1);
      check("stall_valid", {63'd0, if_valid}, 64'd1);
      if (i < 3) step();
    end
    if_ready = 1'b1;
    step();
    check("stall_next", {if_pc, if_instr}, {32'd4, 32'h22});
    wait_halt(20, n);
    check("stall_count", {32'd0, fetch_count}, 64'd4);
    check("stall_sb_empty", 64'(q.size()), 64'd0);

    do_reset();
    q.push_back({32'd0, 32'h11}); q.push_back({32'd4, 32'h22}); q.push_back({32'd12, 32'h44});
    if_ready = 1'b1;
    go();
    step();
    step();
    check("redir_pre_pc", {32'd0, if_pc}, 64'd4);
    check("redir_pre_count", {32'd0, fetch_count}, 64'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_000E;
    step();
    redirect_valid = 1'b0;
    check("redir_flush", {63'd0, if_valid}, 64'd0);
    check("redir_count", {32'd0, fetch_count}, 64'd2);
    check("redir_addr", {32'd0, imem_addr}, 64'd3);
    step();
    check("redir_first", {if_pc, if_instr}, {32'd12, 32'h44});
    wait_halt(20, n);
    check("redir_final_count", {32'd0, fetch_count}, 64'd3);
    check("redir_sb_empty", 64'(q.size()), 64'd0);

    load(64, 99);
    do_reset();
    for (int i = 0; i < 32; i++) q.push_back({32'(i * 4), 32'hA000 + 32'(i) * 32'h11});
    if_ready = 1'b1;
    go();
    wait_halt(60, n);
    check("full_count", {32'd0, fetch_count}, 64'd32);
    check("full_valid", {63'd0, if_valid}, 64'd0);
    check("full_last_pc", {32'd0, if_pc}, 64'h7C);
    check("full_addr", {32'd0, imem_addr}, 64'd32);
    check("full_sb_empty", 64'(q.size()), 64'd0);

    load(2, 2);
    do_reset();
    q.push_back({32'd0, 32'hA000}); q.push_back({32'd4, 32'hA011});
    if_ready = 1'b1;
    go();
    step();
    step();
    if_ready = 1'b0;
    step();
    check("drain_halted", {63'd0, halted}, 64'd0);
    check("drain_held", {if_pc, if_instr}, {32'd4, 32'hA011});
    step();
    check("drain_still", {63'd0, halted, if_valid}, 64'b01);
    check("drain_addr", {32'd0, imem_addr}, 64'd2);
    if_ready = 1'b1;
    step();
    check("drain_done", {63'd0, halted, if_valid}, 64'b10);
    check("drain_count", {32'd0, fetch_count}, 64'd2);
    check("drain_sb_empty", 64'(q.size()), 64'd0);

    do_reset();
    q.push_back({32'd0, 32'hA000}); q.push_back({32'd0, 32'hA000}); q.push_back({32'd4, 32'hA011});
    if_ready = 1'b1;
    go();
    step();
    step();
    if_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    check("dredir_flush", {63'd0, halted, if_valid}, 64'b00);
    check("dredir_addr", {32'd0, imem_addr}, 64'd0);
    if_ready = 1'b1;
    step();
    check("dredir_first", {if_pc, if_instr}, {32'd0, 32'hA000});
    wait_halt(20, n);
    check("dredir_count", {32'd0, fetch_count}, 64'd3);
    check("dredir_sb_empty", 64'(q.size()), 64'd0);

    load(64, 99);
    do_reset();
    for (int i = 0; i < 3; i++) q.push_back({32'(i * 4), 32'hA000 + 32'(i) * 32'h11});
    if_ready = 1'b1;
    go();
    for (int i = 0; i < 4; i++) step();
    check("mid_addr", {32'd0, imem_addr}, 64'd4);
    check("mid_valid", {63'd0, if_valid}, 64'd1);
    reset = 1'b1; if_ready = 1'b0;
    step();
    reset = 1'b0;
    check("mid_rst_valid", {63'd0, if_valid}, 64'd0);
    check("mid_rst_addr", {32'd0, imem_addr}, 64'd0);
    check("mid_rst_count", {32'd0, fetch_count}, 64'd0);
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("mid_idle", {31'd0, imem_addr, if_valid, halted}, 64'd0);
    check("mid_sb_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the word-indexed, combinationally-read instruction memory. It owns the program counter and drives the memory word address. It registers each returned instruction into a valid/ready output stage for decode, and applies branch/jump redirects. When the memory reports an empty word or the PC leaves the populated range, it drains and halts.

Parameters:
RESET_PC, 32'h0000_0000, byte PC loaded on reset (low 2 bits ignored)
MEM_DEPTH, 32, number of populated instruction words; word index >= MEM_DEPTH is treated as end-of-program

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  leave IDLE and begin fetching (sampled in IDLE only)
imem_addr  output  32  word address to instruction memory = {2'b00, pc[31:2]}
imem_data  input  32  instruction word returned combinationally for imem_addr
imem_exit  input  1  memory flags imem_data as empty/invalid (end of program)
redirect_valid  input  1  one-cycle pulse: branch/jump taken
redirect_pc  input  32  byte target for redirect
if_valid  output  1  if_instr/if_pc hold a fetched instruction
if_ready  input  1  decode accepts the instruction this cycle
if_instr  output  32  registered instruction
if_pc  output  32  byte PC of if_instr
halted  output  1  high while in HALT
fetch_count  output  32  instructions accepted by decode (if_valid & if_ready), saturating at 32'hFFFF_FFFF

Behaviour:
- Reset (reset=1 at an edge, any state, mid-operation included): state=IDLE, pc=RESET_PC with [1:0]=0, if_valid=0, if_instr=0, if_pc=0, halted=0, fetch_count=0. Reset overrides every other input.
- imem_addr is combinational from pc at all times, including in IDLE and HALT.
- end_hit = imem_exit | (pc[31:2] >= MEM_DEPTH).
- take = (state==FETCH) & ~end_hit & (~if_valid | if_ready).
- States:
  - IDLE: hold all outputs. start=1 -> FETCH next cycle. redirect_valid is ignored.
  - FETCH:
    - On take: if_instr<=imem_data, if_pc<=pc, pc<=pc+4 (32-bit wrap), if_valid<=1. Latency is one cycle from address to if_valid.
    - If end_hit: no capture. If an instruction is still held and not being accepted, go to DRAIN; otherwise go to HALT.
    - If neither take nor end_hit, and if_valid & if_ready: if_valid<=0.
  - DRAIN: no new fetch; pc is frozen. The held instruction remains visible until accepted. if_valid & if_ready -> if_valid<=0 and state<=HALT.
  - HALT: halted=1, if_valid=0, pc frozen. Leaves only via reset. start and redirect are ignored.
- Redirect (FETCH or DRAIN only) has priority over take/end_hit in the same cycle:
  - pc<=redirect_pc with [1:0] forced to 0; if_valid<=0 (flush); state<=FETCH.
  - If decode handshakes in the same cycle (if_valid & if_ready), that instruction counts as accepted: fetch_count increments, then the flush applies.
  - The first post-redirect instruction appears one cycle later.
- Output stability: while if_valid=1 and if_ready=0, if_instr and if_pc must not change.
- fetch_count increments by 1 on every cycle with if_valid & if_ready (any state), saturating.
- Back-to-back throughput: one instruction per cycle while if_ready=1.

Test Plan:
- Reset with RESET_PC=0, memory words 0..3 = 0x11,0x22,0x33,0x44, word 4 empty; start pulse, if_ready=1 -> if_instr 0x11,0x22,0x33,0x44 on consecutive cycles with if_pc 0,4,8,12; then halted=1; fetch_count=4; imem_addr frozen at 4.
- Same program, if_ready=0 for 3 cycles after first valid -> if_instr=0x11, if_pc=0 held stable and imem_addr stays 1; on if_ready=1, 0x22 follows next cycle with no instruction lost or duplicated.
- While if_pc=4 is valid and accepted, redirect_valid=1 with redirect_pc=0x0000_000E -> fetch_count counts the accepted one; next cycle if_valid=0; following cycle if_pc=0x0C, if_instr=word 3.
- Fill all 32 words (no imem_exit), if_ready=1 -> after if_pc=0x7C, the next cycle has if_valid=0 and halted=1 (out-of-range end), fetch_count=32.
- Word 2 empty, if_ready=0 while word 1 is held -> DRAIN, halted=0; raise if_ready -> one handshake, then halted=1. Redirect to 0 during DRAIN instead -> back to FETCH, word 0 delivered.
- Assert reset for one cycle mid-stream (if_valid=1, pc=0x10) -> next cycle if_valid=0, imem_addr=0, fetch_count=0, state IDLE; no fetch until start.
